// File: rtl/sm3_msg_packer_if.sv
// Word-stream input and 512-bit block output of the SM3 message packer.
interface sm3_msg_packer_if;
  logic         i_valid;
  logic         o_ready;
  logic [31:0]  i_word;
  logic         i_last;
  logic [1:0]   i_last_bytes;
  logic         i_blk_done;
  logic [511:0] o_data;
  logic         o_input_valid;
  logic         o_multi_flag;
  logic         o_m_l_bflag;
  logic [5:0]   o_byte_nums;
  logic         o_err;
`ifdef SM3_PACK_BLKCNT_EN
  logic [31:0]  o_blk_cnt;
`endif

  modport slave (
    input  i_valid, i_word, i_last, i_last_bytes, i_blk_done,
    output o_ready, o_data, o_input_valid, o_multi_flag, o_m_l_bflag,
    output o_byte_nums, o_err
`ifdef SM3_PACK_BLKCNT_EN
    , output o_blk_cnt
`endif
  );

  modport master (
    output i_valid, i_word, i_last, i_last_bytes, i_blk_done,
    input  o_ready, o_data, o_input_valid, o_multi_flag, o_m_l_bflag,
    input  o_byte_nums, o_err
`ifdef SM3_PACK_BLKCNT_EN
    , input o_blk_cnt
`endif
  );
endinterface

// File: rtl/sm3_msg_packer.sv
// Packs a 32-bit big-endian word stream into 512-bit SM3 blocks, one block in flight at a time.
// Optional per-message block counter output o_blk_cnt when SM3_PACK_BLKCNT_EN is defined.
module sm3_msg_packer #(
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  sm3_msg_packer_if.slave   bus
);
  localparam int WORDS_PER_BLK = 16;
  localparam int TW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_EMIT, S_WAIT} state_t;

  state_t         r_state, w_next;
  logic [511:0]   r_buf;
  logic [3:0]     r_wcnt;
  logic [5:0]     r_bytes;
  logic           r_blk_last;
  logic           r_multi;
  logic           r_mlb;
  logic           r_err;
  logic [TW-1:0]  r_tmo;
`ifdef SM3_PACK_BLKCNT_EN
  logic [31:0]    r_blk_cnt;
`endif

  logic           w_ready, w_accept, w_complete, w_done, w_tmo_hit, w_tmo;
  logic [31:0]    w_word_m;
  logic [5:0]     w_inc;
  logic [8:0]     w_lsb;

  assign w_tmo = (DONE_TIMEOUT != 0) && (r_tmo == TW'(DONE_TIMEOUT - 1));
  // Word n lands at bit (15-n)*32; ~r_wcnt is exactly 15-n for a 4-bit count.
  assign w_lsb = {~r_wcnt, 5'b0};

  always_comb begin
    w_word_m = bus.i_word;
    w_inc    = 6'd4;
    if (bus.i_last) begin
      case (bus.i_last_bytes)
        2'd1: begin w_word_m = {bus.i_word[31:24], 24'b0}; w_inc = 6'd1; end
        2'd2: begin w_word_m = {bus.i_word[31:16], 16'b0}; w_inc = 6'd2; end
        2'd3: begin w_word_m = {bus.i_word[31:8], 8'b0};   w_inc = 6'd3; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_ready    = 1'b0;
    w_accept   = 1'b0;
    w_complete = 1'b0;
    w_done     = 1'b0;
    w_tmo_hit  = 1'b0;
    if (i_clear) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_FILL: begin
          w_ready  = 1'b1;
          w_accept = bus.i_valid;
          if (w_accept) begin
            w_next = S_FILL;
            if (bus.i_last || (r_wcnt == 4'(WORDS_PER_BLK - 1))) begin
              w_complete = 1'b1;
              w_next     = S_EMIT;
            end
          end
        end
        S_EMIT: w_next = S_WAIT;
        S_WAIT: begin
          if (bus.i_blk_done) begin
            w_done = 1'b1;
            w_next = r_blk_last ? S_IDLE : S_FILL;
          end else if (w_tmo) begin
            w_tmo_hit = 1'b1;
            w_next    = S_IDLE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_buf      <= '0;
      r_wcnt     <= '0;
      r_bytes    <= '0;
      r_blk_last <= 1'b0;
      r_multi    <= 1'b0;
      r_mlb      <= 1'b0;
      r_err      <= 1'b0;
      r_tmo      <= '0;
`ifdef SM3_PACK_BLKCNT_EN
      r_blk_cnt  <= '0;
`endif
    end else if (i_clear) begin
      r_buf      <= '0;
      r_wcnt     <= '0;
      r_bytes    <= '0;
      r_blk_last <= 1'b0;
      r_multi    <= 1'b0;
      r_mlb      <= 1'b0;
      r_err      <= 1'b0;
      r_tmo      <= '0;
`ifdef SM3_PACK_BLKCNT_EN
      r_blk_cnt  <= '0;
`endif
    end else begin
      if (r_state == S_WAIT) r_tmo <= r_tmo + TW'(1);
      else                   r_tmo <= '0;

      if (w_accept) begin
        // A message's first word starts a fresh block; the old block may still sit in r_buf.
        if (r_state == S_IDLE) begin
          r_buf   <= {w_word_m, 480'b0};
          r_bytes <= w_inc;
        end else begin
          r_buf[w_lsb +: 32] <= w_word_m;
          r_bytes            <= r_bytes + w_inc;
        end
        r_wcnt <= r_wcnt + 4'd1;
        if (w_complete) begin
          r_wcnt     <= '0;
          r_blk_last <= bus.i_last;
          r_multi    <= r_multi | ~bus.i_last;
          r_mlb      <= bus.i_last & r_multi;
`ifdef SM3_PACK_BLKCNT_EN
          if (r_blk_cnt != 32'hFFFF_FFFF) r_blk_cnt <= r_blk_cnt + 32'd1;
`endif
        end
      end

      if (w_done) begin
        r_buf   <= '0;
        r_bytes <= '0;
        if (r_blk_last) begin
          r_multi <= 1'b0;
          r_mlb   <= 1'b0;
`ifdef SM3_PACK_BLKCNT_EN
          r_blk_cnt <= '0;
`endif
        end
      end

      if (w_tmo_hit) begin
        r_err   <= 1'b1;
        r_multi <= 1'b0;
        r_mlb   <= 1'b0;
      end
    end
  end

  assign bus.o_ready       = w_ready & ~i_rst;
  assign bus.o_data        = r_buf;
  assign bus.o_input_valid = (r_state == S_EMIT);
  assign bus.o_multi_flag  = r_multi;
  assign bus.o_m_l_bflag   = r_mlb;
  assign bus.o_byte_nums   = r_bytes;
  assign bus.o_err         = r_err;
`ifdef SM3_PACK_BLKCNT_EN
  assign bus.o_blk_cnt     = r_blk_cnt;
`endif
endmodule

// File: tb/tb_sm3_msg_packer.sv
// Scoreboard bench for sm3_msg_packer: driver queues expected blocks, monitor checks each emit.
module tb_sm3_msg_packer;
  logic clk = 1'b0;
  logic rst;
  logic clear;
  always #5 clk = ~clk;

  sm3_msg_packer_if bus();
  sm3_msg_packer #(.DONE_TIMEOUT(8)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clear(clear),
    .bus    (bus)
  );

  typedef struct {
    logic [511:0] data;
    logic [5:0]   bytes;
    logic         multi;
    logic         mlb;
    logic [31:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   emit_cnt = 0;
  int   done_cnt = 0;
  bit   auto_done = 1'b1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  function automatic logic [511:0] blk(input int first, input int n, input logic [31:0] lastmask);
    logic [511:0] d = '0;
    logic [31:0]  w;
    for (int k = 0; k < n; k++) begin
      w = pat(first + k);
      if (k == n - 1) w = w & lastmask;
      d[511 - 32*k -: 32] = w;
    end
    return d;
  endfunction

  task automatic push(input logic [511:0] d, input logic [5:0] b, input logic m,
                      input logic l, input logic [31:0] c);
    exp_t e;
    e.data = d; e.bytes = b; e.multi = m; e.mlb = l; e.cnt = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every block-valid pulse is matched against the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (bus.o_input_valid === 1'b1) begin
      emit_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_emit actual=emit#%0d required=none", emit_cnt);
      end else begin
        e = exp_q.pop_front();
        chk("o_data", bus.o_data, e.data);
        chk("o_byte_nums", 512'(bus.o_byte_nums), 512'(e.bytes));
        chk("o_multi_flag", 512'(bus.o_multi_flag), 512'(e.multi));
        chk("o_m_l_bflag", 512'(bus.o_m_l_bflag), 512'(e.mlb));
`ifdef SM3_PACK_BLKCNT_EN
        chk("o_blk_cnt", 512'(bus.o_blk_cnt), 512'(e.cnt));
`endif
      end
    end
  end

  // Core model: answers each block after a few cycles, checking that input is stalled meanwhile.
  initial begin
    bus.i_blk_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_input_valid === 1'b1 && auto_done) begin
        repeat (3) @(negedge clk);
        chk("o_ready_in_wait", 512'(bus.o_ready), 512'(0));
        @(posedge clk); #1 bus.i_blk_done = 1'b1;
        @(posedge clk); #1 bus.i_blk_done = 1'b0;
        done_cnt++;
      end
    end
  end

  task automatic send_word(input logic [31:0] w, input logic last, input logic [1:0] lb);
    int n = 0;
    bit acc = 1'b0;
    bus.i_valid = 1'b1; bus.i_word = w; bus.i_last = last; bus.i_last_bytes = lb;
    while (!acc) begin
      @(negedge clk);
      acc = (bus.o_ready === 1'b1);
      @(posedge clk); #1;
      n++;
      if (!acc && n > 200) begin
        checks++;
        failures++;
        $display("FAIL send_word_stall actual=not_accepted required=accepted word=%0h", w);
        acc = 1'b1;
      end
    end
    bus.i_valid = 1'b0; bus.i_last = 1'b0; bus.i_last_bytes = 2'd0;
  endtask

  task automatic send_msg(input int first, input int n, input logic [1:0] lb);
    for (int i = 0; i < n; i++) send_word(pat(first + i), (i == n - 1), lb);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_count", 512'(done_cnt), 512'(target));
    @(negedge clk);
    chk("idle_multi", 512'(bus.o_multi_flag), 512'(0));
    chk("idle_mlb", 512'(bus.o_m_l_bflag), 512'(0));
    chk("idle_ready", 512'(bus.o_ready), 512'(1));
`ifdef SM3_PACK_BLKCNT_EN
    chk("idle_blk_cnt", 512'(bus.o_blk_cnt), 512'(0));
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones = 0;
    rst = 1'b1; clear = 1'b0;
    bus.i_valid = 1'b0; bus.i_word = '0; bus.i_last = 1'b0; bus.i_last_bytes = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 512'(bus.o_ready), 512'(0));
    chk("rst_valid", 512'(bus.o_input_valid), 512'(0));
    chk("rst_data", bus.o_data, 512'(0));
    chk("rst_bytes", 512'(bus.o_byte_nums), 512'(0));
    chk("rst_err", 512'(bus.o_err), 512'(0));
    chk("rst_flags", 512'({bus.o_multi_flag, bus.o_m_l_bflag}), 512'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 512'(bus.o_ready), 512'(1));
    @(posedge clk); #1;

    // Three words, final word carries two bytes.
    push({32'h61626380, 32'h11223344, 32'hAABB0000, 416'b0}, 6'd10, 1'b0, 1'b0, 32'd1);
    send_word(32'h61626380, 1'b0, 2'd0);
    send_word(32'h11223344, 1'b0, 2'd0);
    send_word(32'hAABBCCDD, 1'b1, 2'd2);
    dones += 1; wait_done(dones);

    // Twenty full words: two blocks.
    push(blk(0, 16, 32'hFFFF_FFFF), 6'd0, 1'b1, 1'b0, 32'd1);
    push(blk(16, 4, 32'hFFFF_FFFF), 6'd16, 1'b1, 1'b1, 32'd2);
    send_msg(0, 20, 2'd0);
    dones += 2; wait_done(dones);

    // Exactly sixteen words: one block, no trailing empty block.
    push(blk(100, 16, 32'hFFFF_FFFF), 6'd0, 1'b0, 1'b0, 32'd1);
    send_msg(100, 16, 2'd0);
    dones += 1; wait_done(dones);
    repeat (20) @(posedge clk);
    #1;
    chk("emit_count_16w", 512'(emit_cnt), 512'(4));

    // Core never answers: timeout after eight WAIT cycles.
    auto_done = 1'b0;
    push(blk(200, 2, 32'hFFFF_FF00), 6'd7, 1'b0, 1'b0, 32'd1);
    send_msg(200, 2, 2'd3);
    @(negedge clk);
    chk("tmo_emit", 512'(bus.o_input_valid), 512'(1));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("tmo_err_early", 512'(bus.o_err), 512'(0));
    end
    @(negedge clk);
    chk("tmo_err_set", 512'(bus.o_err), 512'(1));
    chk("tmo_ready", 512'(bus.o_ready), 512'(1));
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    chk("clear_err", 512'(bus.o_err), 512'(0));
    auto_done = 1'b1;
    @(posedge clk); #1;

    // Abort on word five; next message must start in a zeroed buffer.
    for (int i = 0; i < 4; i++) send_word(pat(300 + i), 1'b0, 2'd0);
    bus.i_valid = 1'b1; bus.i_word = pat(304); clear = 1'b1;
    @(negedge clk);
    chk("clear_ready", 512'(bus.o_ready), 512'(0));
    @(posedge clk); #1 clear = 1'b0; bus.i_valid = 1'b0;
    @(negedge clk);
    chk("clear_data", bus.o_data, 512'(0));
    chk("clear_valid", 512'(bus.o_input_valid), 512'(0));
    @(posedge clk); #1;
    push({32'hC000_0000, 480'b0}, 6'd1, 1'b0, 1'b0, 32'd1);
    send_word(pat(400), 1'b1, 2'd1);
    dones += 1; wait_done(dones);

`ifdef SM3_PACK_BLKCNT_EN
    // Forty words: three blocks, counter 1, 2, 3.
    push(blk(500, 16, 32'hFFFF_FFFF), 6'd0, 1'b1, 1'b0, 32'd1);
    push(blk(516, 16, 32'hFFFF_FFFF), 6'd0, 1'b1, 1'b0, 32'd2);
    push(blk(532, 8, 32'hFFFF_FFFF), 6'd32, 1'b1, 1'b1, 32'd3);
    send_msg(500, 40, 2'd0);
    dones += 3; wait_done(dones);
`endif

    repeat (5) @(posedge clk);
    chk("queue_empty", 512'(exp_q.size()), 512'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
